// File: rtl/if_stage_pkg.sv
// Shared RV32I core header: datapath width, reset PC, bubble encoding and major opcodes.
// Also holds the fetch-stage FSM encoding and redirect-target alignment helper.
package if_stage_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // JALR clears bit 0 only; bit 1 is passed through, misalignment is not trapped here.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
        return {target[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/if_stage_pc.sv
// Program counter register: load has priority over hold, otherwise advances by 4.
// Updates on every rising edge; hold freezes the value, wrapping is modulo 2^XLEN.
module if_stage_pc
    import if_stage_pkg::*;
#(
    parameter int          W        = XLEN,
    parameter logic [W-1:0] RST_VAL = RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold,
    input  logic         load,
    input  logic [W-1:0] target,
    output logic [W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RST_VAL;
        end else if (load) begin
            pc <= target;
        end else if (!hold) begin
            pc <= pc + W'(4);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, async imem address, IF/ID register, sticky halt and flush counter.
// Fetch-to-decode latency 1 cycle; stall holds PC and IF/ID, redirect bubbles IF/ID.
module if_stage
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_dout,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_inst,
    output logic            if_id_valid,
    output logic            halted,
    output logic [31:0]     flush_count
);

    fetch_state_t    state, state_next;
    logic            freeze;
    logic            take_redirect;
    logic [XLEN-1:0] pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // halt is acted on in the same edge it is sampled, so a coincident redirect is dropped.
    always_comb begin
        state_next    = state;
        halted        = 1'b0;
        freeze        = 1'b0;
        take_redirect = 1'b0;
        case (state)
            RUN: begin
                if (halt) begin
                    state_next = HALT;
                    freeze     = 1'b1;
                end else begin
                    take_redirect = redirect;
                end
            end
            HALT: begin
                halted = 1'b1;
                freeze = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    if_stage_pc #(
        .W       (XLEN),
        .RST_VAL (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .hold   (freeze || stall),
        .load   (take_redirect),
        .target (align_target(redirect_target)),
        .pc     (pc)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_pc    <= '0;
            if_id_inst  <= NOP;
            if_id_valid <= 1'b0;
            flush_count <= '0;
        end else if (freeze) begin
            if_id_inst  <= NOP;
            if_id_valid <= 1'b0;
        end else if (take_redirect) begin
            if_id_inst  <= NOP;
            if_id_valid <= 1'b0;
            flush_count <= flush_count + 32'd1;
        end else if (!stall) begin
            if_id_pc    <= pc;
            if_id_inst  <= imem_dout;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: directed scenarios then random stimulus vs an architectural model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        halt = 1'b0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] flush_count;

    always #5 clk = ~clk;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_dout       (imem_dout),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .if_id_pc        (if_id_pc),
        .if_id_inst      (if_id_inst),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .flush_count     (flush_count)
    );

    // Word at 0 is 0x00500093 (addi x1,x0,5); other addresses get distinct pseudo-random words.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    assign imem_dout = imem_word(imem_addr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] inst;
        logic        valid;
        logic        hlt;
        logic [31:0] flush;
    } exp_t;

    exp_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;
    bit driver_done = 1'b0;

    // Architectural state of the stage
    logic [31:0] m_pc, m_ifpc, m_inst, m_flush;
    logic        m_valid, m_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] tgt, input bit h);
        exp_t e;
        @(negedge clk);
        reset = r;
        stall = s;
        redirect = rd;
        redirect_target = tgt;
        halt = h;
        if (r) begin
            m_pc = RST_PC; m_ifpc = 0; m_inst = BUBBLE; m_valid = 0; m_halted = 0; m_flush = 0;
        end else if (h || m_halted) begin
            m_halted = 1; m_inst = BUBBLE; m_valid = 0;
        end else if (rd) begin
            m_pc = {tgt[31:1], 1'b0}; m_inst = BUBBLE; m_valid = 0; m_flush = m_flush + 1;
        end else if (!s) begin
            m_ifpc = m_pc; m_inst = imem_word(m_pc); m_valid = 1; m_pc = m_pc + 4;
        end
        e.pc = m_pc; e.ifpc = m_ifpc; e.inst = m_inst;
        e.valid = m_valid; e.hlt = m_halted; e.flush = m_flush;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",          imem_addr,             e.pc);
                check("if_id_pc",    if_id_pc,              e.ifpc);
                check("if_id_inst",  if_id_inst,            e.inst);
                check("if_id_valid", {31'b0, if_id_valid},  {31'b0, e.valid});
                check("halted",      {31'b0, halted},       {31'b0, e.hlt});
                check("flush_count", flush_count,           e.flush);
            end
        end
    end

    initial begin : driver
        logic [31:0] tgt;
        int          sel;
        // reset and free run: pc 4, 8 with IF/ID at 0 then 4
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2);
        // two stall cycles at pc 8, then resume
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(1);
        // redirect beats stall
        step(0, 1, 1, 32'h0000_0100, 0);
        idle(2);
        // odd JALR target
        step(0, 0, 1, 32'h0000_0203, 0);
        idle(1);
        // wrap past the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        idle(2);
        // halt pulse with a coincident redirect, then stay halted until reset
        step(0, 0, 1, 32'h0000_0400, 1);
        step(0, 0, 1, 32'h0000_0500, 0);
        idle(3);
        step(1, 0, 0, 0, 1);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 3);
            tgt = (sel == 0) ? 32'hFFFF_FFFC : (sel == 1) ? ($urandom() | 32'h1) : $urandom();
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 tgt,
                 $urandom_range(0, 59) == 0);
        end
        driver_done = 1'b1;
    end

    initial begin : finisher
        int waited = 0;
        wait (driver_done);
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RV32I core. It holds the PC, drives the asynchronous instruction-memory address, and owns the IF/ID pipeline register whose instruction field feeds the decode-stage control unit. It applies stall requests from the hazard unit, redirects from the execute stage (taken branch, JAL, JALR), and the sticky halt raised by ECALL. Prediction is static not-taken.

## Interface

- XLEN, 32: datapath width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- NOP, 32'h0000_0013: bubble encoding, `addi x0,x0,0`.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- imem_addr  out  XLEN  fetch address, equal to the PC register, combinational from it.
- imem_dout  in  32  instruction returned combinationally for imem_addr.
- stall  in  1  hazard unit load-use stall; hold PC and IF/ID.
- redirect  in  1  execute stage resolved a control transfer different from the fall-through path.
- redirect_target  in  XLEN  new PC when redirect=1.
- halt  in  1  ECALL halt request; one-cycle pulse or level.
- if_id_pc  out  XLEN  PC of the instruction held in IF/ID.
- if_id_inst  out  32  instruction held in IF/ID, consumed by decode/control.
- if_id_valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- halted  out  1  sticky halt status.
- flush_count  out  32  number of cycles in which a redirect flushed IF/ID; wraps modulo 2^32.

## Operation

- State: pc, if_id_pc, if_id_inst, if_id_valid, halted, flush_count.
- Two states: RUN (halted=0) and HALT (halted=1). RUN→HALT when halt=1. HALT is left only by reset.
- Per-edge priority, highest first:
  - reset: pc←RESET_PC, if_id_pc←0, if_id_inst←NOP, if_id_valid←0, halted←0, flush_count←0.
  - halt=1 or halted=1: halted←1; pc holds; IF/ID←bubble (if_id_inst←NOP, if_id_valid←0, if_id_pc holds); flush_count holds.
  - redirect=1, whether or not stall=1:
    - pc←{redirect_target[XLEN-1:1],1'b0}.
    - IF/ID←bubble.
    - flush_count←flush_count+1.
  - stall=1: pc holds, and all IF/ID fields hold.
  - Otherwise: if_id_pc←pc, if_id_inst←imem_dout, if_id_valid←1, pc←pc+4.
- PC arithmetic is XLEN-bit unsigned and wraps from 32'hFFFF_FFFC to 0 without any flag.
- Bit 1 of redirect_target is passed through unchanged. Misalignment trapping is out of scope.
- A redirect in the same cycle as halt is dropped. It does not change pc and does not increment flush_count.

## Timing

- Fetch-to-decode latency: 1 cycle. The instruction at address A appears on if_id_inst in the cycle after pc=A, when there is no stall and no redirect.
- Redirect penalty: the edge that samples redirect=1 loads the target and bubbles IF/ID. The target instruction reaches IF/ID one edge later. This gives one bubble visible to decode in this block. Any older-stage flush belongs to the ID/EX logic.
- Stall is level-sensitive. N stall cycles hold state for exactly N edges.
- halted rises on the edge after halt is first sampled, and stays high.
- Reset asserted mid-stream, including during HALT, restores every reset value on that edge. The first fetch from RESET_PC is latched on the first edge with reset=0.

## Structure

- NOP, RESET_PC default, and the XLEN default live in the shared header alongside the opcode defines.
- One sub-module is natural: `pc_reg`, holding the PC register with its hold and load enables and its reset value.
- The next-PC mux, IF/ID register, halt flag, and flush counter stay in `if_stage`.

## Test plan

- Reset then free run with imem word at 0x0 = 0x00500093 → if_id_pc 0x0, if_id_inst 0x00500093, if_id_valid=1 one cycle after reset release; pc steps 0x4, 0x8, 0xC.
- stall=1 for 2 cycles while pc=0x8 → pc stays 0x8; IF/ID stays at pc 0x4 for both cycles; the next edge latches pc 0x8.
- redirect=1, target 0x100, in the same cycle as stall=1 → pc=0x100, if_id_valid=0, if_id_inst=NOP, flush_count=1; the next edge gives if_id_pc=0x100.
- redirect_target 0x203 (JALR odd target) → pc=0x202.
- One-cycle halt pulse with redirect=1 in the same cycle → halted=1 from the next edge; pc frozen; if_id_valid=0 forever; flush_count unchanged. Assert reset → pc=RESET_PC, halted=0.
- pc preloaded to 0xFFFFFFFC via redirect, then run → next pc=0x0.
